mod_ex_seq: RTL and testbench
=============================

Name: mod_ex_seq

Overview:
Multi-cycle execute sequencer that sits beside the single-cycle ALU in the EX stage. It takes IMUL (0xF7 /5) and shift-group ops (0xC1/0xD1/0xD3, /4 SHL, /5 SHR) from the MEM/EX latch and runs them iteratively. A valid/ready handshake lets the pipeline stall EX while the sequencer is busy. Results, RFLAGS CF/OF updates and the destination tag go to the EX/WB latch.

Parameters:
XLEN, 64, operand width; bit 0 = MSB, bit XLEN-1 = LSB, matching pipeline registers.
CNT_W, 6, shift-count width; count = low CNT_W bits of source.

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
flush  in  1  synchronous kill of in-flight op
in_valid  in  1  op offered
in_ready  out  1  sequencer can accept
in_opcode  in  8  primary opcode
in_regbyte  in  4  ModRM reg field (group selector)
in_rmbyte  in  4  destination register tag
in_a  in  XLEN  RAX (IMUL) / shift source
in_b  in  XLEN  IMUL multiplier / RCX (0xD3)
in_imm  in  XLEN  immediate (0xC1 count)
out_valid  out  1  result held
out_ready  in  1  EX/WB accepts result
out_lo  out  XLEN  RAX / shift result
out_hi  out  XLEN  RDX (IMUL only, else 0)
out_rmbyte  out  4  destination tag echoed
out_opcode  out  8  opcode echoed
out_cf, out_of  out  1 each  flag values
out_flags_we  out  1  CF/OF valid for write
out_err  out  1  unsupported opcode/group
busy  out  1  state != IDLE

Behaviour:
- Reset (reset_n=0 at posedge): state IDLE; out_valid, out_err, out_flags_we, out_cf, out_of = 0; out_lo, out_hi = 0; out_rmbyte = 0; out_opcode = 0; counter = 0.
- States: IDLE, MUL, SHIFT, DONE. in_ready = (state==IDLE). Accept on posedge with in_valid && in_ready. Operands, tag and opcode are latched at accept.
- Accept decode:
  - 0xF7 with regbyte 5 -> MUL, counter=63.
  - 0xC1/0xD1/0xD3 with regbyte 4/5 -> count n = imm[58:63] (C1), 1 (D1), in_b[58:63] (D3). If n=0, go to DONE. Otherwise go to SHIFT with counter=n-1.
  - Anything else -> DONE with out_err=1, out_lo=in_a, out_flags_we=0.
- MUL: operate sign-magnitude. At accept, store |a| and |b| as unsigned XLEN and neg = a[0]^b[0]. Do one shift-add step per cycle for exactly 64 cycles into a 2*XLEN accumulator. On the last step, negate the 128-bit product if neg, then go to DONE. The |0x8000...0| = 2^63 case must be handled exactly.
- MUL flags: out_hi:out_lo = product. out_cf = out_of = (out_hi != {XLEN{out_lo[0]}}). out_flags_we=1.
- SHIFT: shift one bit per cycle, toward MSB for SHL and toward LSB with zero-fill for SHR. CF captures the last bit shifted out. Go to DONE when counter hits 0.
- SHIFT flags and count-0 case:
  - out_flags_we=1 if n>0; n=0 gives out_lo=in_a and out_flags_we=0.
  - out_of is defined only for n=1: SHL gives MSB(result)^CF; SHR gives MSB(original). For n>1, out_of=0.
  - out_hi=0.
- Latency, accept edge to first out_valid cycle: IMUL 65 clocks; shift n+1 clocks; n=0 or error 1 clock.
- DONE: out_valid=1 and all out_* stable until out_valid && out_ready at a posedge, then IDLE. Return to IDLE only; no same-cycle re-accept, so throughput is at most one op per 2 cycles.
- out_ready is ignored outside DONE. in_valid is ignored unless IDLE.
- Flush: flush=1 at a posedge forces IDLE, out_valid=0, out_flags_we=0, from any state. Flush beats accept and beats the DONE handshake in the same cycle. Datapath registers need not clear.
- reset_n dominates flush. Reset mid-MUL or mid-SHIFT abandons the op; nothing leaks to out_valid.

Decomposition:
- Package ex_seq_pkg holds:
  - opcode constants OPC_GRP3=8'hF7, OPC_SHF_IMM=8'hC1, OPC_SHF_1=8'hD1, OPC_SHF_CL=8'hD3;
  - group constants GRP_SHL=4, GRP_SHR=5, GRP_IMUL=5;
  - state enum ex_seq_state_t.
- Sub-module mod_ex_mul_iter holds the shift-add accumulator, the step counter and the final negate. It has a start/done interface, a busy output and a sync clear for flush.

Test Plan:
- IMUL a=-3, b=5 -> after 65 clocks: out_hi=FFFF_FFFF_FFFF_FFFF, out_lo=FFFF_FFFF_FFFF_FFF1, cf=of=0.
- IMUL a=0x8000_0000_0000_0000, b=0x8000_0000_0000_0000 -> out_hi=4000_0000_0000_0000, out_lo=0, cf=of=1; repeat with b=-1 -> hi=0, lo=8000_0000_0000_0000, cf=of=1.
- 0xC1/4, a=0x8000_0000_0000_0001, imm=1 -> valid at 2 clocks, out_lo=2, cf=1, of=1. Same op with imm=0 -> 1 clock, out_lo=a, flags_we=0.
- 0xD3/5, a=0xF0, b=4 -> 5 clocks, out_lo=0xF, cf=0. Then hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0.
- Flush at MUL cycle 30 with in_valid asserted in the same cycle -> next cycle IDLE, no accept. Then opcode 0x01 -> out_err=1 after 1 clock.
- reset_n=0 mid-SHIFT (n=40, cycle 10) -> all outputs at reset values next cycle, in_ready=1 after release.

Source files
------------

// File: rtl/ex_seq_pkg.sv
// Shared opcode/group constants and state type for the EX-stage multi-cycle sequencer.
package ex_seq_pkg;

    localparam logic [7:0] OPC_GRP3    = 8'hF7;
    localparam logic [7:0] OPC_SHF_IMM = 8'hC1;
    localparam logic [7:0] OPC_SHF_1   = 8'hD1;
    localparam logic [7:0] OPC_SHF_CL  = 8'hD3;

    localparam logic [3:0] GRP_SHL  = 4'd4;
    localparam logic [3:0] GRP_SHR  = 4'd5;
    localparam logic [3:0] GRP_IMUL = 4'd5;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StShift,
        StDone
    } ex_seq_state_t;

    function automatic logic is_shift_opc(input logic [7:0] opc);
        return (opc == OPC_SHF_IMM) || (opc == OPC_SHF_1) || (opc == OPC_SHF_CL);
    endfunction

endpackage

// File: rtl/mod_ex_mul_iter.sv
// Iterative sign-magnitude multiplier: one shift-add step per cycle, negate on the last step.
module mod_ex_mul_iter #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clear,
    input  logic            start,
    input  logic [0:XLEN-1] a,
    input  logic [0:XLEN-1] b,
    output logic            busy,
    output logic            done,
    output logic [0:XLEN-1] prod_hi,
    output logic [0:XLEN-1] prod_lo
);

    localparam int unsigned CW = $clog2(XLEN);

    logic [0:2*XLEN-1] mcand_q;
    logic [0:2*XLEN-1] acc_q;
    logic [0:2*XLEN-1] acc_step;
    logic [0:2*XLEN-1] prod;
    logic [0:XLEN-1]   mplier_q;
    logic [0:XLEN-1]   abs_a;
    logic [0:XLEN-1]   abs_b;
    logic [CW-1:0]     cnt_q;
    logic              neg_q;
    logic              busy_q;

    // Two's-complement negation of 0x8000..0 yields 2^63 as an unsigned value, which is exact.
    always_comb begin
        abs_a    = a[0] ? (~a + 1'b1) : a;
        abs_b    = b[0] ? (~b + 1'b1) : b;
        acc_step = acc_q + (mplier_q[XLEN-1] ? mcand_q : '0);
        prod     = neg_q ? (~acc_step + 1'b1) : acc_step;
        prod_hi  = prod[0:XLEN-1];
        prod_lo  = prod[XLEN:2*XLEN-1];
        done     = busy_q && (cnt_q == '0);
        busy     = busy_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else if (clear) begin
            busy_q <= 1'b0;
        end else if (start) begin
            mcand_q  <= {{XLEN{1'b0}}, abs_a};
            mplier_q <= abs_b;
            acc_q    <= '0;
            neg_q    <= a[0] ^ b[0];
            cnt_q    <= CW'(XLEN - 1);
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mod_ex_seq.sv
// EX-stage multi-cycle sequencer for IMUL and the SHL/SHR group, with valid/ready on both sides.
module mod_ex_seq
    import ex_seq_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_opcode,
    input  logic [3:0]      in_regbyte,
    input  logic [3:0]      in_rmbyte,
    input  logic [0:XLEN-1] in_a,
    input  logic [0:XLEN-1] in_b,
    input  logic [0:XLEN-1] in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [0:XLEN-1] out_lo,
    output logic [0:XLEN-1] out_hi,
    output logic [3:0]      out_rmbyte,
    output logic [7:0]      out_opcode,
    output logic            out_cf,
    output logic            out_of,
    output logic            out_flags_we,
    output logic            out_err,
    output logic            busy
);

    ex_seq_state_t state_q, state_d;

    logic [0:XLEN-1]  out_lo_q, out_hi_q;
    logic [3:0]       out_rmbyte_q;
    logic [7:0]       out_opcode_q;
    logic             out_cf_q, out_of_q, out_flags_we_q, out_err_q;

    logic [0:XLEN-1]  shf_q, shf_next;
    logic             shf_bit;
    logic             shl_q, n_one_q, sign_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept, is_mul, is_shf, mul_start, mul_busy, mul_done, mul_ovf;
    logic [CNT_W-1:0] shf_n;
    logic [0:XLEN-1]  mul_hi, mul_lo;
    logic             unused_imm;

    assign unused_imm = ^in_imm[0:XLEN-CNT_W-1];

    always_comb begin
        is_mul = (in_opcode == OPC_GRP3) && (in_regbyte == GRP_IMUL);
        is_shf = is_shift_opc(in_opcode) && ((in_regbyte == GRP_SHL) || (in_regbyte == GRP_SHR));
        if (in_opcode == OPC_SHF_IMM) begin
            shf_n = in_imm[XLEN-CNT_W:XLEN-1];
        end else if (in_opcode == OPC_SHF_1) begin
            shf_n = CNT_W'(1);
        end else begin
            shf_n = in_b[XLEN-CNT_W:XLEN-1];
        end
        accept    = in_valid && (state_q == StIdle) && !flush;
        mul_start = accept && is_mul;
        shf_next  = shl_q ? (shf_q << 1) : (shf_q >> 1);
        shf_bit   = shl_q ? shf_q[0] : shf_q[XLEN-1];
        mul_ovf   = (mul_hi != {XLEN{mul_lo[0]}});
    end

    mod_ex_mul_iter #(
        .XLEN(XLEN)
    ) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (flush),
        .start   (mul_start),
        .a       (in_a),
        .b       (in_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .prod_hi (mul_hi),
        .prod_lo (mul_lo)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d = StMul;
                    end else if (is_shf && (shf_n != '0)) begin
                        state_d = StShift;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StMul:   if (mul_done) state_d = StDone;
            StShift: if (cnt_q == '0) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Flush wins over both accept and the output handshake.
        if (flush) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_lo_q       <= '0;
            out_hi_q       <= '0;
            out_rmbyte_q   <= '0;
            out_opcode_q   <= '0;
            out_cf_q       <= 1'b0;
            out_of_q       <= 1'b0;
            out_flags_we_q <= 1'b0;
            out_err_q      <= 1'b0;
            shf_q          <= '0;
            shl_q          <= 1'b0;
            n_one_q        <= 1'b0;
            sign_q         <= 1'b0;
            cnt_q          <= '0;
        end else if (flush) begin
            out_flags_we_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        out_opcode_q   <= in_opcode;
                        out_rmbyte_q   <= in_rmbyte;
                        out_lo_q       <= in_a;
                        out_hi_q       <= '0;
                        out_cf_q       <= 1'b0;
                        out_of_q       <= 1'b0;
                        out_flags_we_q <= 1'b0;
                        out_err_q      <= !is_mul && !is_shf;
                        shf_q          <= in_a;
                        shl_q          <= (in_regbyte == GRP_SHL);
                        n_one_q        <= (shf_n == CNT_W'(1));
                        sign_q         <= in_a[0];
                        cnt_q          <= shf_n - 1'b1;
                    end
                end
                StMul: begin
                    if (mul_done) begin
                        out_lo_q       <= mul_lo;
                        out_hi_q       <= mul_hi;
                        out_cf_q       <= mul_ovf;
                        out_of_q       <= mul_ovf;
                        out_flags_we_q <= 1'b1;
                    end
                end
                StShift: begin
                    shf_q <= shf_next;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        out_lo_q       <= shf_next;
                        out_cf_q       <= shf_bit;
                        // OF is only architecturally defined for single-bit shifts.
                        out_of_q       <= n_one_q && (shl_q ? (shf_next[0] ^ shf_bit) : sign_q);
                        out_flags_we_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_flags_we_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready     = (state_q == StIdle);
        busy         = (state_q != StIdle);
        out_valid    = (state_q == StDone);
        out_lo       = out_lo_q;
        out_hi       = out_hi_q;
        out_rmbyte   = out_rmbyte_q;
        out_opcode   = out_opcode_q;
        out_cf       = out_cf_q;
        out_of       = out_of_q;
        out_flags_we = out_flags_we_q;
        out_err      = out_err_q;
    end

    logic unused_mul_busy;
    assign unused_mul_busy = mul_busy;

endmodule

// File: tb/tb_mod_ex_seq.sv
// Scoreboard bench for mod_ex_seq: directed ops push expectations, a monitor checks on out_valid.
module tb_mod_ex_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_opcode = '0;
    logic [3:0]  in_regbyte = '0;
    logic [3:0]  in_rmbyte = '0;
    logic [0:63] in_a = '0;
    logic [0:63] in_b = '0;
    logic [0:63] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [0:63] out_lo, out_hi;
    logic [3:0]  out_rmbyte;
    logic [7:0]  out_opcode;
    logic        out_cf, out_of, out_flags_we, out_err, busy;

    typedef struct {
        logic [63:0] lo;
        logic [63:0] hi;
        logic        cf;
        logic        of;
        logic        fwe;
        logic        err;
        logic [3:0]  rm;
        logic [7:0]  opc;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_valid = 1'b0;

    mod_ex_seq dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_regbyte   (in_regbyte),
        .in_rmbyte    (in_rmbyte),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_imm       (in_imm),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_lo       (out_lo),
        .out_hi       (out_hi),
        .out_rmbyte   (out_rmbyte),
        .out_opcode   (out_opcode),
        .out_cf       (out_cf),
        .out_of       (out_of),
        .out_flags_we (out_flags_we),
        .out_err      (out_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Monitor: compare on the first cycle of each out_valid pulse.
    always @(negedge clk) begin
        if (out_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
                chk("out_lo", out_lo, e.lo);
                chk("out_hi", out_hi, e.hi);
                chk("out_flags_we", 64'(out_flags_we), 64'(e.fwe));
                chk("out_err", 64'(out_err), 64'(e.err));
                chk("out_rmbyte", 64'(out_rmbyte), 64'(e.rm));
                chk("out_opcode", 64'(out_opcode), 64'(e.opc));
                if (e.fwe) begin
                    chk("out_cf", 64'(out_cf), 64'(e.cf));
                    chk("out_of", 64'(out_of), 64'(e.of));
                end
            end
        end
        prev_valid = out_valid;
    end

    function automatic exp_t mk(input logic [63:0] lo, input logic [63:0] hi, input logic cf,
                                input logic of, input logic fwe, input logic err, input int lat);
        exp_t e;
        e.lo = lo; e.hi = hi; e.cf = cf; e.of = of; e.fwe = fwe; e.err = err;
        e.lat = lat; e.rm = '0; e.opc = '0; e.acc = 0;
        return e;
    endfunction

    task automatic issue(input logic [7:0] opc, input logic [3:0] rg, input logic [3:0] rm,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] imm,
                         input bit push, input exp_t e_in);
        exp_t e;
        int   n;
        e = e_in;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
        in_valid = 1'b1; in_opcode = opc; in_regbyte = rg; in_rmbyte = rm;
        in_a = a; in_b = b; in_imm = imm;
        e.acc = cyc + 1; e.opc = opc; e.rm = rm;
        if (push) sb.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        exp_t nul;
        nul = mk('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_lo", out_lo, 64'd0);
        chk("rst_out_flags_we", 64'(out_flags_we), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        issue(8'hF7, 4'd5, 4'd1, -64'sd3, 64'd5, '0, 1'b1,
              mk(64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 65));
        issue(8'hF7, 4'd5, 4'd2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, '0, 1'b1,
              mk(64'd0, 64'h4000_0000_0000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 65));
        issue(8'hF7, 4'd5, 4'd3, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, '0, 1'b1,
              mk(64'h8000_0000_0000_0000, 64'd0, 1'b1, 1'b1, 1'b1, 1'b0, 65));
        issue(8'hC1, 4'd4, 4'd4, 64'h8000_0000_0000_0001, '0, 64'd1, 1'b1,
              mk(64'd2, 64'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2));
        issue(8'hC1, 4'd4, 4'd5, 64'h8000_0000_0000_0001, '0, 64'd0, 1'b1,
              mk(64'h8000_0000_0000_0001, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1));
        issue(8'hD1, 4'd5, 4'd6, 64'h8000_0000_0000_0003, '0, '0, 1'b1,
              mk(64'h4000_0000_0000_0001, 64'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2));
        // Count is the low 6 bits of the immediate: 0x44 -> 4.
        issue(8'hC1, 4'd5, 4'd7, 64'h123C, '0, 64'h44, 1'b1,
              mk(64'h123, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5));
        issue(8'hC1, 4'd4, 4'd8, 64'hE000_0000_0000_0000, '0, 64'd3, 1'b1,
              mk(64'd0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4));
        issue(8'hF7, 4'd4, 4'd9, 64'hDEAD_BEEF, 64'd7, '0, 1'b1,
              mk(64'hDEAD_BEEF, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1));
        drain();

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        issue(8'hD3, 4'd5, 4'd10, 64'hF0, 64'd4, '0, 1'b1,
              mk(64'hF, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5));
        begin
            int n;
            n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_out_lo", out_lo, 64'hF);
            chk("hold_flags_we", 64'(out_flags_we), 64'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_handshake_valid", 64'(out_valid), 64'd0);
        drain();

        // Flush mid-multiply with a competing offer in the same cycle.
        issue(8'hF7, 4'd5, 4'd11, 64'd9, 64'd9, '0, 1'b0, nul);
        repeat (29) @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1; in_opcode = 8'hD1; in_regbyte = 4'd4; in_a = 64'd1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_flags_we", 64'(out_flags_we), 64'd0);
        repeat (70) @(negedge clk);
        chk("flush_no_late_valid", 64'(out_valid), 64'd0);
        issue(8'h01, 4'd0, 4'd12, 64'h55, '0, '0, 1'b1,
              mk(64'h55, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1));
        drain();

        // Reset in the middle of a 40-bit shift.
        issue(8'hD3, 4'd4, 4'd13, 64'd1, 64'd40, '0, 1'b0, nul);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_lo", out_lo, 64'd0);
        chk("mid_rst_rmbyte", 64'(out_rmbyte), 64'd0);
        chk("mid_rst_opcode", 64'(out_opcode), 64'd0);
        chk("mid_rst_err", 64'(out_err), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        repeat (45) @(negedge clk);
        chk("post_rst_no_valid", 64'(out_valid), 64'd0);
        issue(8'hD1, 4'd4, 4'd14, 64'h4000_0000_0000_0000, '0, '0, 1'b1,
              mk(64'h8000_0000_0000_0000, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got %0d want %0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
